// File: rtl/lane_judge_pkg.sv
// Shared grade encodings, score weights and a saturation helper for the lane judge.
package lane_judge_pkg;

    localparam logic [1:0] GRADE_MISS    = 2'd0;
    localparam logic [1:0] GRADE_GOOD    = 2'd1;
    localparam logic [1:0] GRADE_PERFECT = 2'd2;

    localparam logic [1:0] SCORE_PERFECT = 2'd3;
    localparam logic [1:0] SCORE_GOOD    = 2'd1;

    function automatic logic [15:0] sat16(input logic [31:0] v);
        return (v > 32'h0000_FFFF) ? 16'hFFFF : v[15:0];
    endfunction

endpackage

// File: rtl/lane_judge_if.sv
// Bundles the chart ROM, key and renderer/score signals of the lane judge.
interface lane_judge_if #(
    parameter int unsigned LANES     = 4,
    parameter int unsigned TRACK_LEN = 480,
    parameter int unsigned ADDR_W    = 11
) ();

    logic                       run;
    logic [LANES-1:0]           key;
    logic [ADDR_W-1:0]          chart_addr;
    logic [LANES-1:0]           chart_data;
    logic [LANES*TRACK_LEN-1:0] track;
    logic [LANES-1:0]           judge_valid;
    logic [2*LANES-1:0]         judge_grade;
    logic [31:0]                score;
    logic [15:0]                combo;
    logic [15:0]                max_combo;
    logic                       done;

    modport master (
        output run, key, chart_data,
        input  chart_addr, track, judge_valid, judge_grade, score, combo, max_combo, done
    );

    modport slave (
        input  run, key, chart_data,
        output chart_addr, track, judge_valid, judge_grade, score, combo, max_combo, done
    );

endinterface

// File: rtl/lane_scroller.sv
// One lane: note shift register, hit-window search with head clear, miss detection and grading.
module lane_scroller
    import lane_judge_pkg::*;
#(
    parameter int unsigned TRACK_LEN   = 480,
    parameter int unsigned HIT_POS     = 445,
    parameter int unsigned WIN_PERFECT = 2,
    parameter int unsigned WIN_GOOD    = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 load,
    input  logic                 din,
    input  logic                 press,
    output logic [TRACK_LEN-1:0] track,
    output logic [TRACK_LEN-1:0] track_next,
    output logic                 hit,
    output logic                 miss,
    output logic [1:0]           grade,
    output logic [1:0]           weight
);

    localparam int unsigned WinLo  = HIT_POS - WIN_GOOD;
    localparam int unsigned WinHi  = HIT_POS + WIN_GOOD;
    localparam int unsigned PerfLo = HIT_POS - WIN_PERFECT;
    localparam int unsigned PerfHi = HIT_POS + WIN_PERFECT;

    logic [TRACK_LEN-1:0] track_q;
    logic [TRACK_LEN-1:0] clear;
    logic [TRACK_LEN-1:0] kept;
    logic                 found;
    logic                 perfect;

    always_comb begin
        found   = 1'b0;
        perfect = 1'b0;
        clear   = '0;
        // Ascending scan: the last match is the highest index, i.e. the oldest note.
        for (int unsigned i = WinLo; i <= WinHi; i++) begin
            if (track_q[i]) begin
                found    = 1'b1;
                clear    = '0;
                clear[i] = 1'b1;
                perfect  = (i >= PerfLo) && (i <= PerfHi);
            end
        end
    end

    always_comb begin
        hit  = press && found;
        kept = hit ? (track_q & ~clear) : track_q;
        // A head taken by a press this cycle can no longer fall out as a miss.
        miss = tick && kept[WinHi];
        if (hit) begin
            grade  = perfect ? GRADE_PERFECT : GRADE_GOOD;
            weight = perfect ? SCORE_PERFECT : SCORE_GOOD;
        end else begin
            grade  = GRADE_MISS;
            weight = 2'd0;
        end
        track_next = tick ? {kept[TRACK_LEN-2:0], load & din} : kept;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            track_q <= '0;
        end else begin
            track_q <= track_next;
        end
    end

    assign track = track_q;

endmodule

// File: rtl/lane_judge.sv
// N-lane note scroller and hit judge: scroll/row timing, chart addressing, score and combo.
module lane_judge
    import lane_judge_pkg::*;
#(
    parameter int unsigned LANES       = 4,
    parameter int unsigned TRACK_LEN   = 480,
    parameter int unsigned HIT_POS     = 445,
    parameter int unsigned WIN_PERFECT = 2,
    parameter int unsigned WIN_GOOD    = 6,
    parameter int unsigned FALL_DIV    = 800000,
    parameter int unsigned READ_DIV    = 140,
    parameter int unsigned ADDR_W      = 11,
    parameter int unsigned CHART_LEN   = 2048
) (
    input logic         clk,
    input logic         rst,
    lane_judge_if.slave bus
);

    localparam int unsigned FallW  = (FALL_DIV > 1) ? $clog2(FALL_DIV) : 1;
    localparam int unsigned RowW   = (READ_DIV > 1) ? $clog2(READ_DIV) : 1;
    // One spare bit so the address can sit at CHART_LEN even when CHART_LEN = 2**ADDR_W.
    localparam int unsigned AddrW1 = ADDR_W + 1;
    localparam logic [AddrW1-1:0] ChartEnd = AddrW1'(CHART_LEN);

    logic [FallW-1:0]           fall_q, fall_d;
    logic [RowW-1:0]            row_q, row_d;
    logic [AddrW1-1:0]          addr_q, addr_d;
    logic [LANES-1:0]           key_q;
    logic [LANES-1:0]           press;
    logic [LANES-1:0]           hit;
    logic [LANES-1:0]           miss;
    logic [LANES-1:0]           valid_q, valid_d;
    logic [2*LANES-1:0]         grade_q, grade_d;
    logic [1:0]                 lane_grade  [LANES];
    logic [1:0]                 lane_weight [LANES];
    logic [LANES*TRACK_LEN-1:0] track_all;
    logic [LANES*TRACK_LEN-1:0] track_next_all;
    logic [31:0]                score_q, score_d;
    logic [15:0]                combo_q, combo_d;
    logic [15:0]                max_q, max_d;
    logic                       done_q, done_d;
    logic                       tick;
    logic                       row_tick;
    logic                       exhausted;
    logic                       load;

    always_comb begin
        tick      = bus.run && (fall_q == FallW'(FALL_DIV - 1));
        row_tick  = tick && (row_q == RowW'(READ_DIV - 1));
        exhausted = (addr_q == ChartEnd);
        load      = row_tick && !exhausted;

        fall_d = fall_q;
        if (bus.run) begin
            fall_d = tick ? '0 : fall_q + FallW'(1);
        end
        row_d = row_q;
        if (tick) begin
            row_d = row_tick ? '0 : row_q + RowW'(1);
        end
        addr_d = load ? addr_q + AddrW1'(1) : addr_q;

        // Edges seen while frozen are dropped; key_q still follows the key.
        press = bus.run ? (bus.key & ~key_q) : '0;
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        lane_scroller #(
            .TRACK_LEN  (TRACK_LEN),
            .HIT_POS    (HIT_POS),
            .WIN_PERFECT(WIN_PERFECT),
            .WIN_GOOD   (WIN_GOOD)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .tick      (tick),
            .load      (load),
            .din       (bus.chart_data[l]),
            .press     (press[l]),
            .track     (track_all[l*TRACK_LEN +: TRACK_LEN]),
            .track_next(track_next_all[l*TRACK_LEN +: TRACK_LEN]),
            .hit       (hit[l]),
            .miss      (miss[l]),
            .grade     (lane_grade[l]),
            .weight    (lane_weight[l])
        );
    end

    always_comb begin
        int unsigned hits;
        int unsigned wsum;
        logic [31:0] combo_sum;
        logic [32:0] score_sum;

        hits    = 0;
        wsum    = 0;
        valid_d = '0;
        grade_d = '0;
        for (int l = 0; l < LANES; l++) begin
            hits              = hits + 32'(hit[l]);
            wsum              = wsum + 32'(lane_weight[l]);
            valid_d[l]        = hit[l] | miss[l];
            grade_d[2*l +: 2] = lane_grade[l];
        end

        combo_sum = ((|miss) ? 32'd0 : 32'(combo_q)) + hits;
        combo_d   = sat16(combo_sum);
        max_d     = (combo_d > max_q) ? combo_d : max_q;

        score_sum = {1'b0, score_q} + 33'(wsum);
        score_d   = score_sum[32] ? 32'hFFFF_FFFF : score_sum[31:0];

        done_d = (addr_d == ChartEnd) && (track_next_all == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fall_q  <= '0;
            row_q   <= '0;
            addr_q  <= '0;
            key_q   <= '0;
            valid_q <= '0;
            grade_q <= '0;
            score_q <= '0;
            combo_q <= '0;
            max_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            fall_q  <= fall_d;
            row_q   <= row_d;
            addr_q  <= addr_d;
            key_q   <= bus.key;
            valid_q <= valid_d;
            grade_q <= grade_d;
            score_q <= score_d;
            combo_q <= combo_d;
            max_q   <= max_d;
            done_q  <= done_d;
        end
    end

    assign bus.chart_addr  = addr_q[ADDR_W-1:0];
    assign bus.track       = track_all;
    assign bus.judge_valid = valid_q;
    assign bus.judge_grade = grade_q;
    assign bus.score       = score_q;
    assign bus.combo       = combo_q;
    assign bus.max_combo   = max_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_lane_judge.sv
// Directed table-driven bench for lane_judge on a short 4-row chart with a small track.
module tb_lane_judge;

    localparam int unsigned LANES     = 4;
    localparam int unsigned TRACK_LEN = 32;
    localparam int unsigned ADDR_W    = 3;

    typedef struct {
        int          e;
        logic [3:0]  key;
        logic [3:0]  v;
        logic [7:0]  g;
        int unsigned sc;
        int unsigned cb;
        int unsigned mx;
        int unsigned ad;
        logic        dn;
        int          tp;
        logic        tv;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    int         cyc;
    int         checks = 0;
    int         errors = 0;
    logic [3:0] rom [8];
    vec_t       vecs [18];

    lane_judge_if #(.LANES(LANES), .TRACK_LEN(TRACK_LEN), .ADDR_W(ADDR_W)) bus ();

    lane_judge #(
        .LANES      (LANES),
        .TRACK_LEN  (TRACK_LEN),
        .HIT_POS    (24),
        .WIN_PERFECT(1),
        .WIN_GOOD   (3),
        .FALL_DIV   (4),
        .READ_DIV   (8),
        .ADDR_W     (ADDR_W),
        .CHART_LEN  (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Chart ROM with one cycle of read latency.
    always @(posedge clk) bus.chart_data <= rom[bus.chart_addr];

    // Edge counter since reset release; edge n is the n-th posedge with rst high.
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic at_edge(input int e);
        while (cyc < e) begin
            @(posedge clk);
            #1;
        end
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, 32'(bus.judge_valid), 0);
        chk({tag, "_grade"}, 32'(bus.judge_grade), 0);
        chk({tag, "_score"}, bus.score, 0);
        chk({tag, "_combo"}, 32'(bus.combo), 0);
        chk({tag, "_max"}, 32'(bus.max_combo), 0);
        chk({tag, "_addr"}, 32'(bus.chart_addr), 0);
        chk({tag, "_done"}, 32'(bus.done), 0);
        chk({tag, "_track"}, 32'(|bus.track), 0);
    endtask

    initial begin
        rom[0] = 4'b0001;
        rom[1] = 4'b1111;
        rom[2] = 4'b0001;
        rom[3] = 4'b0001;
        for (int i = 4; i < 8; i++) rom[i] = 4'b0000;

        //            e   key    v     g      sc  cb  mx  ad  dn    tp  tv
        vecs[0]  = '{  1, 4'h0, 4'h0, 8'h00,  0,  0,  0,  0, 1'b0,  0, 1'b0};
        vecs[1]  = '{128, 4'h1, 4'h0, 8'h00,  0,  0,  0,  4, 1'b0, 24, 1'b1};
        vecs[2]  = '{129, 4'h0, 4'h1, 8'h02,  3,  1,  1,  4, 1'b0, 24, 1'b0};
        vecs[3]  = '{130, 4'h0, 4'h0, 8'h00,  3,  1,  1,  4, 1'b0, 24, 1'b0};
        vecs[4]  = '{160, 4'hF, 4'h0, 8'h00,  3,  1,  1,  4, 1'b0, 56, 1'b1};
        vecs[5]  = '{161, 4'h0, 4'hF, 8'hAA, 15,  5,  5,  4, 1'b0, 56, 1'b0};
        vecs[6]  = '{170, 4'h4, 4'h0, 8'h00, 15,  5,  5,  4, 1'b0, 88, 1'b0};
        vecs[7]  = '{171, 4'h0, 4'h0, 8'h00, 15,  5,  5,  4, 1'b0, 88, 1'b0};
        vecs[8]  = '{183, 4'h1, 4'h0, 8'h00, 15,  5,  5,  4, 1'b0, 21, 1'b1};
        vecs[9]  = '{184, 4'h1, 4'h1, 8'h01, 16,  6,  6,  4, 1'b0, 22, 1'b0};
        vecs[10] = '{224, 4'h1, 4'h0, 8'h00, 16,  6,  6,  4, 1'b0, 24, 1'b1};
        vecs[11] = '{225, 4'h1, 4'h0, 8'h00, 16,  6,  6,  4, 1'b0, 24, 1'b1};
        vecs[12] = '{236, 4'h1, 4'h0, 8'h00, 16,  6,  6,  4, 1'b0, 27, 1'b1};
        vecs[13] = '{240, 4'h0, 4'h1, 8'h00, 16,  0,  6,  4, 1'b0, 28, 1'b1};
        vecs[14] = '{241, 4'h0, 4'h0, 8'h00, 16,  0,  6,  4, 1'b0, 28, 1'b1};
        vecs[15] = '{255, 4'h0, 4'h0, 8'h00, 16,  0,  6,  4, 1'b0, 31, 1'b1};
        vecs[16] = '{256, 4'h0, 4'h0, 8'h00, 16,  0,  6,  4, 1'b1, 31, 1'b0};
        vecs[17] = '{300, 4'h0, 4'h0, 8'h00, 16,  0,  6,  4, 1'b1,  0, 1'b0};

        rst      = 1'b0;
        bus.run  = 1'b1;
        bus.key  = '0;
        #23;
        check_zero("reset");
        rst = 1'b1;

        for (int i = 0; i < 18; i++) begin
            at_edge(vecs[i].e);
            chk($sformatf("v%0d_valid", i), 32'(bus.judge_valid), 32'(vecs[i].v));
            chk($sformatf("v%0d_grade", i), 32'(bus.judge_grade), 32'(vecs[i].g));
            chk($sformatf("v%0d_score", i), bus.score, vecs[i].sc);
            chk($sformatf("v%0d_combo", i), 32'(bus.combo), vecs[i].cb);
            chk($sformatf("v%0d_max", i), 32'(bus.max_combo), vecs[i].mx);
            chk($sformatf("v%0d_addr", i), 32'(bus.chart_addr), vecs[i].ad);
            chk($sformatf("v%0d_done", i), 32'(bus.done), 32'(vecs[i].dn));
            chk($sformatf("v%0d_track", i), 32'(bus.track[vecs[i].tp]), 32'(vecs[i].tv));
            bus.key = vecs[i].key;
        end

        // Reset after the chart is done must clear score, max combo and done.
        #1;
        rst = 1'b0;
        #1;
        check_zero("rst_after_done");
        @(negedge clk);
        rst = 1'b1;

        // Freeze with a head on the hit line, press while frozen, resume holding the key.
        at_edge(130);
        bus.run = 1'b0;
        at_edge(135);
        bus.key = 4'h1;
        at_edge(137);
        chk("frz_valid", 32'(bus.judge_valid), 0);
        chk("frz_track24", 32'(bus.track[24]), 1);
        chk("frz_score", bus.score, 0);
        chk("frz_addr", 32'(bus.chart_addr), 4);
        at_edge(140);
        bus.run = 1'b1;
        at_edge(142);
        chk("resume_valid", 32'(bus.judge_valid), 0);
        chk("resume_score", bus.score, 0);
        chk("resume_combo", 32'(bus.combo), 0);

        // Asynchronous reset in the middle of a song.
        at_edge(150);
        chk("pre_rst_track", 32'(|bus.track), 1);
        chk("pre_rst_addr", 32'(bus.chart_addr), 4);
        #1;
        rst = 1'b0;
        #1;
        check_zero("rst_mid_song");
        bus.key = '0;
        @(negedge clk);
        rst = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
